note_matcher_multi: RTL
=======================

NOTE_MATCHER_MULTI -- requirements
Module: note_matcher_multi

Interface
REQ-001 Parameter LANES, default 5: number of independent note lanes (fret buttons), range 1..8.
REQ-002 Parameter TW, default 16: width of all time values, in 10 ms ticks.
REQ-003 Parameter WINDOW, default 100: match/timeout window in ticks.
REQ-004 Parameter PERFECT, default 5: maximum error, in ticks, graded as perfect.
REQ-005 clk  in  1: single clock; all state updates on its rising edge.
REQ-006 reset  in  1: synchronous, active-low reset.
REQ-007 pause  in  1: high = game paused; note_edge is ignored.
REQ-008 song_time  in  TW: current song time.
REQ-009 note_edge  in  LANES: per-lane single-cycle press pulse.
REQ-010 note_time  in  LANES*TW: per-lane next-note time, lane i at [i*TW +: TW]; all-ones = end of song.
REQ-011 note_available  in  LANES: per-lane note_time valid.
REQ-012 note_request  out  LANES: per-lane request for the next note.
REQ-013 match_enable  out  LANES: per-lane one-cycle match pulse.
REQ-014 match_time / match_err  out  LANES*TW each: per-lane matched note time / absolute timing error.
REQ-015 match_late  out  LANES: per-lane flag, 1 = press after note time (past slot).
REQ-016 miss_enable  out  LANES; miss_time  out  LANES*TW: per-lane one-cycle pulse and time of a note dropped unmatched.
REQ-017 hit_count, perfect_count, miss_count, ghost_count  out  16 each: saturating statistics.

Function
REQ-018 Each lane SHALL hold a future slot and a past slot, each with an explicit valid bit; time 0 is a legal note time.
REQ-019 Lane FSM SHALL be FETCH (future invalid, note_request=1) -> ARMED (future valid, note_request=0) -> FETCH on future consumption; DONE is terminal until reset.
REQ-020 Transfer SHALL occur only in a cycle with note_request[i]=1 and note_available[i]=1; the next cycle future is valid and note_request[i]=0.
REQ-021 A transferred all-ones note_time SHALL move the lane to DONE (no load, note_request[i]=0); the past slot keeps operating.
REQ-022 Promotion: if future valid, fut_time < song_time and no future match this cycle, the future SHALL move to past and the lane returns to FETCH.
REQ-023 If promotion overwrites a valid, unmatched past note, that note SHALL be reported as a miss.
REQ-024 Timeout: if past valid and song_time > past_time + WINDOW (TW+1-bit compare), past SHALL be invalidated and reported as a miss.
REQ-025 Press (note_edge[i]=1, pause=0): d_past = song_time - past_time, d_fut = fut_time - song_time.
REQ-026 Press SHALL match past if past valid, d_past <= WINDOW, and (future invalid or d_past < d_fut); otherwise future if future valid and d_fut < WINDOW; otherwise it is a ghost.
REQ-027 Matched slot SHALL be invalidated; a matched slot is never also promoted, timed out, or missed in the same cycle.
REQ-028 Match outputs SHALL appear the cycle after the press: match_enable=1 for exactly one cycle, match_time, match_err (d_past or d_fut), match_late (1 = past).
REQ-029 A matched future slot SHALL return the lane to FETCH; past-match plus promotion in one cycle SHALL leave the promoted note valid in past, no miss.
REQ-030 Miss outputs SHALL pulse one cycle after the triggering evaluation; past-overwrite and timeout cannot coincide in one lane in one cycle.
REQ-031 Each counter SHALL add the popcount of its qualifying lanes per cycle, saturating at 16'hFFFF; perfect_count counts matches with match_err <= PERFECT.
REQ-032 pause SHALL suppress presses only; fetch, promotion, and timeout continue against song_time.
REQ-033 match_* and miss_* fields SHALL hold their last values between pulses.

Reset
REQ-034 While reset=0: all slots invalid, FSMs in FETCH, and every output (including note_request and counters) 0.
REQ-035 note_request SHALL assert on the first clock edge after reset returns high; reset asserted mid-handshake discards the pending transfer.

Verification (LANES=2, WINDOW=100, PERFECT=5)
- Release reset -> note_request=2'b11 next cycle; note_available[0]=1, note_time[0]=500 -> note_request[0]=0 next cycle.
- Future 500, song_time 497, press lane 0 -> next cycle: match_enable[0]=1, match_time 500, err 3, late 0; hit_count 1, perfect_count 1.
- Future 500, song_time 501 -> promotion; load 700; press at 520 -> match past: err 20, late 1; perfect_count unchanged.
- Past 500, no press -> no miss at song_time 600; at 601: miss_enable[0] pulses, miss_time 500, miss_count 1.
- Future 900, song_time 700, press -> no match, ghost_count 1; all-ones transfer -> lane DONE, note_request stays 0.
- Both lanes press with valid matches in one cycle -> match_enable=2'b11, hit_count +2; reset=0 mid-fetch -> all outputs 0 next cycle.

Source files
------------

// File: rtl/note_matcher_multi.sv
// note_matcher_multi
//   Multi-lane rhythm-game note matcher. Each lane keeps a "future" slot (the
//   next upcoming note) and a "past" slot (the most recent note whose time has
//   gone by). A press is matched against whichever slot is closer in time.
//   Notes that are never matched are reported as misses. Presses that match
//   nothing are counted as ghosts.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   pause           1 = presses ignored; fetch/promotion/timeout keep running
//   song_time       current song time in ticks
//   note_edge       per-lane single-cycle press pulse
//   note_time       per-lane next-note time (lane i at [i*TW +: TW]), all-ones = end
//   note_available  per-lane note_time valid
//   note_request    per-lane request for the next note
//   match_enable    per-lane one-cycle match pulse
//   match_time      per-lane time of the matched note (held between pulses)
//   match_err       per-lane absolute timing error (held between pulses)
//   match_late      per-lane 1 = press after note time (held between pulses)
//   miss_enable     per-lane one-cycle miss pulse
//   miss_time       per-lane time of the missed note (held between pulses)
//   hit_count, perfect_count, miss_count, ghost_count: saturating statistics

module note_matcher_multi #(
  parameter int LANES   = 5,
  parameter int TW      = 16,
  parameter int WINDOW  = 100,
  parameter int PERFECT = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pause,
  input  logic [TW-1:0]       song_time,
  input  logic [LANES-1:0]    note_edge,
  input  logic [LANES*TW-1:0] note_time,
  input  logic [LANES-1:0]    note_available,
  output logic [LANES-1:0]    note_request,
  output logic [LANES-1:0]    match_enable,
  output logic [LANES*TW-1:0] match_time,
  output logic [LANES*TW-1:0] match_err,
  output logic [LANES-1:0]    match_late,
  output logic [LANES-1:0]    miss_enable,
  output logic [LANES*TW-1:0] miss_time,
  output logic [15:0]         hit_count,
  output logic [15:0]         perfect_count,
  output logic [15:0]         miss_count,
  output logic [15:0]         ghost_count
);

  typedef enum logic [1:0] {FETCH, ARMED, DONE} lane_state_t;

  localparam logic [TW-1:0] WIN       = TW'(WINDOW);
  localparam logic [TW:0]   WIN_X     = (TW+1)'(WINDOW);
  localparam logic [TW-1:0] PERF      = TW'(PERFECT);
  localparam logic [TW-1:0] END_MARK  = '1;

  lane_state_t       state_q [LANES];
  lane_state_t       state_d [LANES];
  logic [TW-1:0]     fut_time_q  [LANES];
  logic [TW-1:0]     past_time_q [LANES];
  logic [TW-1:0]     d_past [LANES];
  logic [TW-1:0]     d_fut  [LANES];
  logic [LANES-1:0]  past_valid_q, past_valid_d;
  logic [LANES-1:0]  fut_valid, press, past_ok, fut_ok;
  logic [LANES-1:0]  match_past, match_fut, match_any, ghost, perfect;
  logic [LANES-1:0]  promote, timeout, miss, load;
  logic [3:0]        n_hit, n_perfect, n_miss, n_ghost;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Per-lane slot evaluation and lane next-state. The past slot wins a press
  // only when it is strictly closer than a valid future note. The unsigned
  // d_fut wraps when the future note is already behind song_time, so such a
  // note can never be matched as "future"; it gets promoted instead.
  always_comb begin
    n_hit     = '0;
    n_perfect = '0;
    n_miss    = '0;
    n_ghost   = '0;
    for (int i = 0; i < LANES; i++) begin
      fut_valid[i]  = (state_q[i] == ARMED);
      press[i]      = note_edge[i] & ~pause;
      d_past[i]     = song_time - past_time_q[i];
      d_fut[i]      = fut_time_q[i] - song_time;
      past_ok[i]    = past_valid_q[i] && (d_past[i] <= WIN) &&
                      (!fut_valid[i] || (d_past[i] < d_fut[i]));
      fut_ok[i]     = fut_valid[i] && (d_fut[i] < WIN);
      match_past[i] = press[i] && past_ok[i];
      match_fut[i]  = press[i] && !past_ok[i] && fut_ok[i];
      match_any[i]  = match_past[i] || match_fut[i];
      ghost[i]      = press[i] && !past_ok[i] && !fut_ok[i];
      perfect[i]    = (match_past[i] && (d_past[i] <= PERF)) ||
                      (match_fut[i]  && (d_fut[i]  <= PERF));
      promote[i]    = fut_valid[i] && (fut_time_q[i] < song_time) && !match_fut[i];
      timeout[i]    = past_valid_q[i] && !match_past[i] &&
                      ({1'b0, song_time} > ({1'b0, past_time_q[i]} + WIN_X));
      miss[i]       = past_valid_q[i] && !match_past[i] && (promote[i] || timeout[i]);
      load[i]       = (state_q[i] == FETCH) && note_request[i] && note_available[i];

      past_valid_d[i] = past_valid_q[i];
      if (promote[i])
        past_valid_d[i] = 1'b1;
      else if (match_past[i] || timeout[i])
        past_valid_d[i] = 1'b0;

      state_d[i] = state_q[i];
      case (state_q[i])
        FETCH:
          if (load[i])
            state_d[i] = (note_time[i*TW +: TW] == END_MARK) ? DONE : ARMED;
        ARMED:
          if (promote[i] || match_fut[i])
            state_d[i] = FETCH;
        default:
          state_d[i] = DONE;
      endcase

      n_hit     = n_hit     + {3'b000, match_any[i]};
      n_perfect = n_perfect + {3'b000, perfect[i]};
      n_miss    = n_miss    + {3'b000, miss[i]};
      n_ghost   = n_ghost   + {3'b000, ghost[i]};
    end
  end

  // note_request is registered from the next state so it stays low during
  // reset and rises on the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i]     <= FETCH;
        fut_time_q[i]  <= '0;
        past_time_q[i] <= '0;
      end
      past_valid_q  <= '0;
      note_request  <= '0;
      match_enable  <= '0;
      match_time    <= '0;
      match_err     <= '0;
      match_late    <= '0;
      miss_enable   <= '0;
      miss_time     <= '0;
      hit_count     <= '0;
      perfect_count <= '0;
      miss_count    <= '0;
      ghost_count   <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i]      <= state_d[i];
        note_request[i] <= (state_d[i] == FETCH);
        if (load[i] && (note_time[i*TW +: TW] != END_MARK))
          fut_time_q[i] <= note_time[i*TW +: TW];
        if (promote[i])
          past_time_q[i] <= fut_time_q[i];
        if (match_any[i]) begin
          match_time[i*TW +: TW] <= match_past[i] ? past_time_q[i] : fut_time_q[i];
          match_err[i*TW +: TW]  <= match_past[i] ? d_past[i] : d_fut[i];
          match_late[i]          <= match_past[i];
        end
        if (miss[i])
          miss_time[i*TW +: TW] <= past_time_q[i];
      end
      past_valid_q  <= past_valid_d;
      match_enable  <= match_any;
      miss_enable   <= miss;
      hit_count     <= sat_add(hit_count, n_hit);
      perfect_count <= sat_add(perfect_count, n_perfect);
      miss_count    <= sat_add(miss_count, n_miss);
      ghost_count   <= sat_add(ghost_count, n_ghost);
    end
  end

endmodule
